// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, constants and burst-address helpers for the memory slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slv_state_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Beat count of a fixed-length burst; 0 means unbounded (INCR).
    function automatic logic [4:0] burst_beats(input hburst_t burst);
        case (burst)
            HBURST_SINGLE:                return 5'd1;
            HBURST_WRAP4, HBURST_INCR4:   return 5'd4;
            HBURST_WRAP8, HBURST_INCR8:   return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                      return 5'd0;
        endcase
    endfunction

    // Next beat address; WRAPn keeps the upper bits fixed above the n*2^size boundary.
    function automatic logic [63:0] wrap_next(input logic [63:0] addr, input logic [2:0] size,
                                             input hburst_t burst);
        logic [63:0] incr;
        logic [63:0] bnd_mask;
        incr = 64'd1 << size;
        case (burst)
            HBURST_WRAP4:  bnd_mask = (incr << 2) - 64'd1;
            HBURST_WRAP8:  bnd_mask = (incr << 3) - 64'd1;
            HBURST_WRAP16: bnd_mask = (incr << 4) - 64'd1;
            default:       bnd_mask = '1;
        endcase
        return (addr & ~bnd_mask) | ((addr + incr) & bnd_mask);
    endfunction

endpackage

// File: rtl/ahb_slave_mem_ram.sv
// Word-wide memory array with per-byte write enables; written on the clock, read combinationally.
module ahb_slave_mem_ram #(
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic                         clk,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    input  logic [DATA_W/8-1:0]          byte_en,
    input  logic [DATA_W-1:0]            wdata,
    output logic [DATA_W-1:0]            rdata
);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (byte_en[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: configurable width/depth/base, wait states, byte lanes,
// two-cycle ERROR response and SEQ-beat address checking.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                MEM_WORDS   = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [1:0]        HTRANS,
    input  logic [DATA_W-1:0] HWDATA,
    output logic              HREADY,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA,
    output slv_state_t        state_dbg
);

    localparam int         BYTES     = DATA_W / 8;
    localparam int         OFF_W     = $clog2(BYTES);
    localparam int         IDX_W     = $clog2(MEM_WORDS);
    localparam int         LOC_W     = OFF_W + IDX_W;
    localparam logic [2:0] MAX_SIZE  = (DATA_W == 64) ? HSIZE_DWORD : HSIZE_WORD;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    htrans_t           trans;
    hburst_t           burst;
    slv_state_t        state, state_nxt;
    logic [LOC_W-1:0]  addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic [3:0]        wait_cnt;
    logic [DATA_W-1:0] hrdata_q, rd_data;
    logic [BYTES-1:0]  byte_en;
    logic              trk_active, trk_fixed;
    logic [ADDR_W-1:0] trk_next;
    logic [2:0]        trk_size;
    hburst_t           trk_burst;
    logic [4:0]        trk_left;
    logic              capture, range_err, size_err, align_err, seq_err, xfer_err;
    logic [7:0]        align_mask;

    assign trans     = htrans_t'(HTRANS);
    assign burst     = hburst_t'(HBURST);
    assign state_dbg = state;

    // Base is aligned to the region size, so decoding is an upper-bit compare.
    assign range_err  = HADDR[ADDR_W-1:LOC_W] != BASE_ADDR[ADDR_W-1:LOC_W];
    assign size_err   = HSIZE > MAX_SIZE;
    assign align_mask = (8'd1 << HSIZE) - 8'd1;
    assign align_err  = |(HADDR[7:0] & align_mask);
    assign seq_err    = (trans == HTRANS_SEQ) && (!trk_active || HADDR != trk_next);
    assign xfer_err   = range_err | size_err | align_err | seq_err;
    assign capture    = HREADY && HSEL && HTRANS[1];

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_WAIT: state_nxt = (wait_cnt == 4'd0) ? ST_DATA : ST_WAIT;
            ST_ERR1: state_nxt = ST_ERR2;
            default: begin
                if (capture) begin
                    if (xfer_err)             state_nxt = ST_ERR1;
                    else if (WAIT_STATES > 0) state_nxt = ST_WAIT;
                    else                      state_nxt = ST_DATA;
                end
            end
        endcase
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        HRDATA = hrdata_q;
        case (state)
            ST_WAIT: HREADY = 1'b0;
            ST_DATA: if (!write_q) HRDATA = rd_data;
            ST_ERR1: begin
                HREADY = 1'b0;
                HRESP  = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
            wait_cnt <= 4'd0;
            hrdata_q <= '0;
        end else begin
            if (capture) begin
                addr_q  <= HADDR[LOC_W-1:0];
                write_q <= HWRITE;
                size_q  <= HSIZE;
            end
            if (capture && !xfer_err)                       wait_cnt <= WAIT_LOAD;
            else if (state == ST_WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
            if (state == ST_DATA && !write_q)               hrdata_q <= rd_data;
        end
    end

    // Burst tracker follows every accepted address phase, including BUSY/IDLE.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            trk_active <= 1'b0;
            trk_fixed  <= 1'b0;
            trk_next   <= '0;
            trk_size   <= 3'd0;
            trk_burst  <= HBURST_SINGLE;
            trk_left   <= 5'd0;
        end else if (HREADY && HSEL) begin
            case (trans)
                HTRANS_IDLE: trk_active <= 1'b0;
                HTRANS_NONSEQ: begin
                    trk_active <= !xfer_err && (burst != HBURST_SINGLE);
                    trk_fixed  <= burst_beats(burst) != 5'd0;
                    trk_left   <= burst_beats(burst) - 5'd1;
                    trk_size   <= HSIZE;
                    trk_burst  <= burst;
                    trk_next   <= ADDR_W'(wrap_next(64'(HADDR), HSIZE, burst));
                end
                HTRANS_SEQ: begin
                    if (xfer_err || (trk_fixed && trk_left == 5'd1)) trk_active <= 1'b0;
                    trk_left <= trk_left - 5'd1;
                    trk_next <= ADDR_W'(wrap_next(64'(HADDR), trk_size, trk_burst));
                end
                default: ;
            endcase
        end
    end

    // Lanes are fixed to byte address, so a byte at offset 1 lives in HWDATA[15:8].
    always_comb begin
        byte_en = '0;
        if (state == ST_DATA && write_q)
            byte_en = BYTES'(((16'd1 << (16'd1 << size_q)) - 16'd1) << addr_q[OFF_W-1:0]);
    end

    ahb_slave_mem_ram #(
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_ram (
        .clk     (HCLK),
        .addr    (addr_q[LOC_W-1:OFF_W]),
        .byte_en (byte_en),
        .wdata   (HWDATA),
        .rdata   (rd_data)
    );

endmodule
